// File: rtl/crc32_framer.sv
// CRC-32 stream framer: forwards framed bytes and appends the
// reflected IEEE 802.3 CRC, least significant byte first.
module crc32 (
  input  logic [31:0] c,
  input  logic [7:0]  d,
  output logic [31:0] newcrc
);
  localparam logic [31:0] POLY = 32'h04C11DB7;

  // MSB-first shift of d into the non-reflected register
  always_comb begin
    logic fb;
    newcrc = c;
    for (int i = 7; i >= 0; i--) begin
      fb     = newcrc[31] ^ d[i];
      newcrc = {newcrc[30:0], 1'b0} ^ ({32{fb}} & POLY);
    end
  end
endmodule

module crc32_framer #(
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [31:0] crc_out,
  output logic        crc_done,
  output logic [15:0] frame_cnt
);
  typedef enum logic [2:0] {
    S_DATA,
    S_CRC0,
    S_CRC1,
    S_CRC2,
    S_CRC3
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] crc_q, crc_n;
  logic [31:0] newcrc;
  logic [7:0]  d_rev;
  logic [7:0]  m_data_n;
  logic        m_valid_n, m_last_n;
  logic [31:0] crc_out_n;
  logic        crc_done_n;
  logic [15:0] frame_cnt_n;
  logic        adv;
  logic        accept;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) d_rev[i] = s_data[7-i];
  end

  crc32 u_core (
    .c      (crc_q),
    .d      (d_rev),
    .newcrc (newcrc)
  );

  assign adv     = !m_valid || m_ready;
  assign s_ready = (state_q == S_DATA) && adv;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_n     = state_q;
    crc_n       = crc_q;
    m_data_n    = m_data;
    m_valid_n   = m_valid;
    m_last_n    = m_last;
    crc_out_n   = crc_out;
    crc_done_n  = 1'b0;
    frame_cnt_n = frame_cnt;
    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          m_data_n  = s_data;
          m_valid_n = 1'b1;
          m_last_n  = 1'b0;
          crc_n     = newcrc;
          if (s_last) begin
            crc_out_n   = rev32(newcrc) ^ XOROUT;
            crc_done_n  = 1'b1;
            frame_cnt_n = frame_cnt + 16'd1;
            state_n     = S_CRC0;
          end
        end else if (adv) begin
          m_valid_n = 1'b0;
        end
      end
      S_CRC0: begin
        if (adv) begin
          m_data_n  = crc_out[7:0];
          m_valid_n = 1'b1;
          m_last_n  = 1'b0;
          state_n   = S_CRC1;
        end
      end
      S_CRC1: begin
        if (adv) begin
          m_data_n  = crc_out[15:8];
          m_valid_n = 1'b1;
          m_last_n  = 1'b0;
          state_n   = S_CRC2;
        end
      end
      S_CRC2: begin
        if (adv) begin
          m_data_n  = crc_out[23:16];
          m_valid_n = 1'b1;
          m_last_n  = 1'b0;
          state_n   = S_CRC3;
        end
      end
      S_CRC3: begin
        if (adv) begin
          m_data_n  = crc_out[31:24];
          m_valid_n = 1'b1;
          m_last_n  = 1'b1;
          crc_n     = INIT;
          state_n   = S_DATA;
        end
      end
      default: state_n = S_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DATA;
      crc_q     <= INIT;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      crc_out   <= 32'h0;
      crc_done  <= 1'b0;
      frame_cnt <= 16'h0;
    end else begin
      state_q   <= state_n;
      crc_q     <= crc_n;
      m_data    <= m_data_n;
      m_valid   <= m_valid_n;
      m_last    <= m_last_n;
      crc_out   <= crc_out_n;
      crc_done  <= crc_done_n;
      frame_cnt <= frame_cnt_n;
    end
  end
endmodule

// File: doc/crc32_framer.md
# crc32_framer

Stream-level sequencer for the byte-wide `crc32` next-state core. It accepts framed bytes on a valid/ready input and forwards them through one register stage. At each frame end it stalls the input and appends the 4-byte CRC-32 (IEEE 802.3, reflected, LSB byte first). It sits between the capture packetizer and the host link, so every frame leaving the analyzer carries its own checksum.

## Interface
Parameters:
- `INIT`, 32'hFFFFFFFF, CRC register value at reset and at each frame start.
- `XOROUT`, 32'hFFFFFFFF, XOR applied to the reflected register to form the final CRC.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_data`  in  8  input byte.
- `s_valid`  in  1  input byte valid.
- `s_last`  in  1  marks the final data byte of a frame; qualified by `s_valid`.
- `s_ready`  out  1  block accepts `s_data` this cycle.
- `m_data`  out  8  output byte: data or CRC.
- `m_valid`  out  1  output byte valid.
- `m_last`  out  1  set on the 4th CRC byte only.
- `m_ready`  in  1  downstream accepts `m_data`.
- `crc_out`  out  32  final CRC of the most recently completed frame.
- `crc_done`  out  1  one-cycle pulse when `crc_out` updates.
- `frame_cnt`  out  16  completed-frame counter; wraps modulo 2^16.

## Operation
- The block instantiates one `crc32` core:
  - `c` = internal register `crc_q`.
  - `d` = bit-reversed `s_data` (`d[i] = s_data[7-i]`).
- Final value: `F = bitrev32(newcrc) ^ XOROUT`, where `newcrc` is the core output for the `s_last` byte.
- FSM states, with the transfer condition `adv = !m_valid || m_ready`:
  - DATA:
    - `s_ready = adv`. On accept (`s_valid && s_ready`): `m_data <= s_data`, `m_valid <= 1`, `m_last <= 0`, `crc_q <= newcrc`.
    - If `s_last` is also set: latch F into `crc_out`, pulse `crc_done`, increment `frame_cnt`, go to CRC0.
    - If `adv` holds but no byte is accepted: `m_valid <= 0`.
  - CRC0..CRC3:
    - `s_ready = 0`.
    - When `adv`: `m_data <= crc_out[8k+7:8k]` for state CRCk, `m_valid <= 1`, `m_last <= (k==3)`, advance to the next state.
    - On leaving CRC3: go to DATA and set `crc_q <= INIT`.
- Output hold rule: while `m_valid && !m_ready`, `m_data`, `m_valid` and `m_last` are held unchanged.
- Frame length: a frame always has at least one data byte, because `s_last` tags a data byte. There are no zero-length frames.
- Reset values: state DATA, `crc_q = INIT`, `m_valid = 0`, `m_last = 0`, `m_data = 0`, `crc_out = 0`, `crc_done = 0`, `frame_cnt = 0`. `s_ready` follows the DATA rule, so it is 1 after reset.
- Reset mid-frame: the partial frame and any pending CRC bytes are discarded with no output. The next accepted byte starts a new frame from INIT.

## Timing
- Latency: a byte accepted in cycle t appears on `m_data`/`m_valid` in cycle t+1.
- `crc_out` and `crc_done` are valid in cycle t+1 after the `s_last` accept.
- The first CRC byte is driven the cycle after the last data byte is taken downstream.
- Throughput with `m_ready = 1` throughout: an N-byte frame occupies N+4 output cycles. `s_ready` is low for exactly the 4 CRC cycles.
- Frames can run back to back: the first byte of the next frame is accepted in the same cycle CRC3 is transferred.
- `frame_cnt` wraps from 0xFFFF to 0x0000 with no flag.
- `s_ready` is combinational from `m_valid`/`m_ready`/state. No combinational path runs from `s_valid` to `m_*`.

## Test plan
- **Standard check value.** Input "123456789" (0x31..0x39), `s_last` on 0x39, `m_ready = 1`.
  - Output: the 9 bytes, then 0x26, 0x39, 0xF4, 0xCB, with `m_last` on 0xCB.
  - `crc_out = 0xCBF43926`, one `crc_done` pulse, `frame_cnt = 1`.
- **Single-byte frame.** Input 0x00 with `s_last`.
  - Output: 0x00, 0x8D, 0xEF, 0x02, 0xD2.
  - `crc_out = 0xD202EF8D`.
- **Backpressure.** Same frame as the first scenario, with `m_ready` following a pseudo-random pattern.
  - The output byte sequence is identical to the first scenario.
  - `m_data` is stable whenever `m_valid && !m_ready`.
  - No byte is lost or duplicated, and `s_ready = 0` throughout the CRC bytes.
- **Back-to-back frames.** Two "123456789" frames sent with `s_valid` held high.
  - Both frames end in 26 39 F4 CB, confirming the reinit to INIT.
  - The second frame's first byte is accepted in the CRC3 transfer cycle.
  - Total 26 output cycles, `frame_cnt = 2`.
- **Reset mid-frame.** Assert `rst_n = 0` after 4 bytes of a frame.
  - All outputs immediately (asynchronously) take their reset values.
  - A following "123456789" frame again yields 0xCBF43926.
- **Counter wrap.** Force 65536 one-byte frames.
  - `frame_cnt` goes from 0xFFFF to 0x0000.
  - `crc_done` pulses 65536 times.
